// File: rtl/calendar_pkg.sv
// Shared types, constants and date helpers for the calendar_date block.
package calendar_pkg;

    localparam int unsigned FIELD_W   = 7;
    localparam int unsigned DIM_W     = 5;
    localparam int unsigned BLINK_W   = 6;
    localparam int unsigned WDAY_W    = 3;
    localparam int unsigned YEAR_MAX  = 99;
    localparam int unsigned MONTH_MAX = 12;

    typedef enum logic [1:0] {
        ST_NORM  = 2'd0,
        ST_SET_Y = 2'd1,
        ST_SET_M = 2'd2,
        ST_SET_D = 2'd3
    } state_e;

    localparam logic [BLINK_W-1:0] BLINK_NORM = 6'b000000;
    localparam logic [BLINK_W-1:0] BLINK_Y    = 6'b110000;
    localparam logic [BLINK_W-1:0] BLINK_M    = 6'b001100;
    localparam logic [BLINK_W-1:0] BLINK_D    = 6'b000011;

    // Blink code shown for a given state; shared format with the clock block.
    function automatic logic [BLINK_W-1:0] blink_of(input state_e st);
        logic [BLINK_W-1:0] code;
        code = BLINK_NORM;
        case (st)
            ST_SET_Y: code = BLINK_Y;
            ST_SET_M: code = BLINK_M;
            ST_SET_D: code = BLINK_D;
            default:  code = BLINK_NORM;
        endcase
        return code;
    endfunction

    // Sakamoto month-offset table: 0,3,2,5,0,3,5,1,4,6,2,4 for Jan..Dec.
    function automatic logic [2:0] sakamoto_offset(input logic [FIELD_W-1:0] month);
        logic [2:0] off;
        off = 3'd0;
        case (month)
            7'd1:    off = 3'd0;
            7'd2:    off = 3'd3;
            7'd3:    off = 3'd2;
            7'd4:    off = 3'd5;
            7'd5:    off = 3'd0;
            7'd6:    off = 3'd3;
            7'd7:    off = 3'd5;
            7'd8:    off = 3'd1;
            7'd9:    off = 3'd4;
            7'd10:   off = 3'd6;
            7'd11:   off = 3'd2;
            7'd12:   off = 3'd4;
            default: off = 3'd0;
        endcase
        return off;
    endfunction

    // Day of week (0 = Sunday) for 2000+year / month / day.
    function automatic logic [WDAY_W-1:0] weekday_of(input logic [FIELD_W-1:0] year,
                                                     input logic [FIELD_W-1:0] month,
                                                     input logic [FIELD_W-1:0] day);
        int unsigned y;
        int unsigned s;
        y = 32'd2000 + 32'(year);
        if (month < 7'd3) y = y - 32'd1;
        s = y + y / 32'd4 - y / 32'd100 + y / 32'd400
            + 32'(sakamoto_offset(month)) + 32'(day);
        return WDAY_W'(s % 32'd7);
    endfunction

endpackage

// File: rtl/calendar_date_if.sv
// Button/carry inputs and date/display outputs of calendar_date.
// Optional weekday output present when CALENDAR_WEEKDAY_EN is defined.
interface calendar_date_if;
    import calendar_pkg::*;

    logic                 mode;
    logic                 up;
    logic                 down;
    logic                 left;
    logic                 right;
    logic                 enter;
    logic                 esc;
    logic                 day_carry;
    logic                 norm;
    logic [FIELD_W-1:0]   year;
    logic [FIELD_W-1:0]   month;
    logic [FIELD_W-1:0]   day;
    logic [BLINK_W-1:0]   blink;
`ifdef CALENDAR_WEEKDAY_EN
    logic [WDAY_W-1:0]    weekday;
`endif

    modport master (
        output mode, up, down, left, right, enter, esc, day_carry,
`ifdef CALENDAR_WEEKDAY_EN
        input  weekday,
`endif
        input  norm, year, month, day, blink
    );

    modport slave (
        input  mode, up, down, left, right, enter, esc, day_carry,
`ifdef CALENDAR_WEEKDAY_EN
        output weekday,
`endif
        output norm, year, month, day, blink
    );

endinterface

// File: rtl/cal_month_len.sv
// Combinational days-in-month lookup for a given month and leap flag.
module cal_month_len
    import calendar_pkg::*;
(
    input  logic [FIELD_W-1:0] month,
    input  logic               leap,
    output logic [DIM_W-1:0]   dim_c
);

    always_comb begin
        dim_c = 5'd31;
        case (month)
            7'd2:                    dim_c = leap ? 5'd29 : 5'd28;
            7'd4, 7'd6, 7'd9, 7'd11: dim_c = 5'd30;
            default:                 dim_c = 5'd31;
        endcase
    end

endmodule

// File: rtl/calendar_date.sv
// Year/month/day keeper (2000-2099) advanced by the clock's midnight carry,
// with button-driven set mode. Define CALENDAR_WEEKDAY_EN for a weekday output.
module calendar_date
    import calendar_pkg::*;
#(
    parameter int unsigned RESET_YEAR  = 17,
    parameter int unsigned RESET_MONTH = 6,
    parameter int unsigned RESET_DAY   = 13
) (
    input  logic            clk,
    input  logic            rst_n,
    calendar_date_if.slave  bus
);

    localparam int unsigned BTN_W = 6;

    state_e             state_q, state_n;
    logic [FIELD_W-1:0] year_q, month_q, day_q;
    logic [FIELD_W-1:0] year_a, month_a, day_a, day_n;
    logic               norm_q;
    logic [BLINK_W-1:0] blink_q;
    logic [BTN_W-1:0]   btn_lvl, btn_q, btn_p;
    logic               carry_q, carry_ev;
    logic [DIM_W-1:0]   dim_cur, dim_new;

    // Button order: up, down, left, right, enter, esc.
    assign btn_lvl  = {bus.up, bus.down, bus.left, bus.right, bus.enter, bus.esc};
    assign btn_p    = btn_lvl & ~btn_q;
    assign carry_ev = bus.day_carry & ~carry_q;

    logic up_p, down_p, left_p, right_p, enter_p, esc_p;
    assign {up_p, down_p, left_p, right_p, enter_p, esc_p} = btn_p;

    // Month length of the current date drives advance and day-field wrap.
    cal_month_len u_dim_cur (
        .month (month_q),
        .leap  (year_q[1:0] == 2'b00),
        .dim_c (dim_cur)
    );

    // Month length of the adjusted date drives the day clamp.
    cal_month_len u_dim_new (
        .month (month_a),
        .leap  (year_a[1:0] == 2'b00),
        .dim_c (dim_new)
    );

    // Next state and adjusted date fields.
    always_comb begin
        state_n = state_q;
        year_a  = year_q;
        month_a = month_q;
        day_a   = day_q;
        unique case (state_q)
            ST_NORM: begin
                if (bus.mode && enter_p) state_n = ST_SET_Y;
                if (carry_ev) begin
                    if (day_q >= FIELD_W'(dim_cur)) begin
                        day_a = 7'd1;
                        if (month_q >= FIELD_W'(MONTH_MAX)) begin
                            month_a = 7'd1;
                            year_a  = (year_q >= FIELD_W'(YEAR_MAX)) ? 7'd0 : year_q + 7'd1;
                        end else begin
                            month_a = month_q + 7'd1;
                        end
                    end else begin
                        day_a = day_q + 7'd1;
                    end
                end
            end
            ST_SET_Y, ST_SET_M, ST_SET_D: begin
                if (bus.mode) begin
                    if (esc_p) begin
                        state_n = ST_NORM;
                    end else begin
                        if (left_p && !right_p) begin
                            case (state_q)
                                ST_SET_Y: state_n = ST_SET_D;
                                ST_SET_D: state_n = ST_SET_M;
                                default:  state_n = ST_SET_Y;
                            endcase
                        end else if (right_p && !left_p) begin
                            case (state_q)
                                ST_SET_Y: state_n = ST_SET_M;
                                ST_SET_M: state_n = ST_SET_D;
                                default:  state_n = ST_SET_Y;
                            endcase
                        end
                        // Adjust targets the field blinking before any move.
                        if (up_p ^ down_p) begin
                            case (state_q)
                                ST_SET_Y: begin
                                    if (up_p) year_a = (year_q >= FIELD_W'(YEAR_MAX)) ? 7'd0 : year_q + 7'd1;
                                    else      year_a = (year_q == 7'd0) ? FIELD_W'(YEAR_MAX) : year_q - 7'd1;
                                end
                                ST_SET_M: begin
                                    if (up_p) month_a = (month_q >= FIELD_W'(MONTH_MAX)) ? 7'd1 : month_q + 7'd1;
                                    else      month_a = (month_q <= 7'd1) ? FIELD_W'(MONTH_MAX) : month_q - 7'd1;
                                end
                                default: begin
                                    if (up_p) day_a = (day_q >= FIELD_W'(dim_cur)) ? 7'd1 : day_q + 7'd1;
                                    else      day_a = (day_q <= 7'd1) ? FIELD_W'(dim_cur) : day_q - 7'd1;
                                end
                            endcase
                        end
                    end
                end
            end
            default: state_n = ST_NORM;
        endcase
    end

    // Clamp the day to the length of the (possibly changed) month.
    always_comb begin
        day_n = day_a;
        if (day_a > FIELD_W'(dim_new)) day_n = FIELD_W'(dim_new);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_NORM;
            year_q  <= FIELD_W'(RESET_YEAR);
            month_q <= FIELD_W'(RESET_MONTH);
            day_q   <= FIELD_W'(RESET_DAY);
            norm_q  <= 1'b1;
            blink_q <= BLINK_NORM;
            btn_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_n;
            year_q  <= year_a;
            month_q <= month_a;
            day_q   <= day_n;
            norm_q  <= (state_n == ST_NORM);
            blink_q <= blink_of(state_n);
            btn_q   <= btn_lvl;
            carry_q <= bus.day_carry;
        end
    end

    assign bus.norm  = norm_q;
    assign bus.year  = year_q;
    assign bus.month = month_q;
    assign bus.day   = day_q;
    assign bus.blink = blink_q;

`ifdef CALENDAR_WEEKDAY_EN
    localparam logic [WDAY_W-1:0] RESET_WDAY =
        weekday_of(FIELD_W'(RESET_YEAR), FIELD_W'(RESET_MONTH), FIELD_W'(RESET_DAY));

    logic [WDAY_W-1:0] wday_q;

    // Weekday follows the registered date one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wday_q <= RESET_WDAY;
        else        wday_q <= weekday_of(year_q, month_q, day_q);
    end

    assign bus.weekday = wday_q;
`endif

endmodule

// File: tb/tb_calendar_date.sv
// Directed self-checking bench for calendar_date (reset 2017-06-13).
module tb_calendar_date;

    localparam logic [5:0] B_UP  = 6'b100000;
    localparam logic [5:0] B_DN  = 6'b010000;
    localparam logic [5:0] B_L   = 6'b001000;
    localparam logic [5:0] B_R   = 6'b000100;
    localparam logic [5:0] B_EN  = 6'b000010;
    localparam logic [5:0] B_ESC = 6'b000001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    calendar_date_if bus ();

    calendar_date #(
        .RESET_YEAR  (17),
        .RESET_MONTH (6),
        .RESET_DAY   (13)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int ey, em, ed;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    task automatic check_date(input string tag, input int y, input int m, input int d);
        check({tag, ".year"},  int'(bus.year),  y);
        check({tag, ".month"}, int'(bus.month), m);
        check({tag, ".day"},   int'(bus.day),   d);
    endtask

    function automatic int dim_of(input int y, input int m);
        case (m)
            2:             return (y % 4 == 0) ? 29 : 28;
            4, 6, 9, 11:   return 30;
            default:       return 31;
        endcase
    endfunction

    // One-cycle button pulse, then release; result visible on return.
    task automatic press(input logic [5:0] m);
        @(negedge clk);
        {bus.up, bus.down, bus.left, bus.right, bus.enter, bus.esc} = m;
        @(negedge clk);
        {bus.up, bus.down, bus.left, bus.right, bus.enter, bus.esc} = 6'b0;
    endtask

    task automatic carry_edge();
        @(negedge clk);
        bus.day_carry = 1'b1;
        repeat (2) @(negedge clk);
        bus.day_carry = 1'b0;
        @(negedge clk);
    endtask

    // From NORM: enter set mode, walk each field up to target; ends in SET_D.
    task automatic set_date(input int ty, input int tm, input int td);
        press(B_EN);
        while (ey != ty) begin
            press(B_UP);
            ey = (ey + 1) % 100;
            if (ed > dim_of(ey, em)) ed = dim_of(ey, em);
        end
        press(B_R);
        while (em != tm) begin
            press(B_UP);
            em = em % 12 + 1;
            if (ed > dim_of(ey, em)) ed = dim_of(ey, em);
        end
        press(B_R);
        while (ed != td) begin
            press(B_UP);
            ed = (ed >= dim_of(ey, em)) ? 1 : ed + 1;
        end
        check_date("set", ty, tm, td);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.mode = 1'b1;
        {bus.up, bus.down, bus.left, bus.right, bus.enter, bus.esc} = 6'b0;
        bus.day_carry = 1'b0;
        ey = 17; em = 6; ed = 13;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.norm", int'(bus.norm), 1);
        check("rst.blink", int'(bus.blink), 0);
        check_date("rst", 17, 6, 13);
`ifdef CALENDAR_WEEKDAY_EN
        check("rst.weekday", int'(bus.weekday), 2);
`endif

        // Asynchronous reset while setting the month
        press(B_EN);
        press(B_R);
        check("setm.blink", int'(bus.blink), 12);
        check("setm.norm", int'(bus.norm), 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst.norm", int'(bus.norm), 1);
        check("arst.blink", int'(bus.blink), 0);
        check_date("arst", 17, 6, 13);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`ifdef CALENDAR_WEEKDAY_EN
        check("arst.weekday", int'(bus.weekday), 2);
`endif

        // Buttons ignored when not foreground
        bus.mode = 1'b0;
        press(B_EN);
        check("mode0.norm", int'(bus.norm), 1);
        bus.mode = 1'b1;

        // Field navigation
        press(B_EN);        check("nav.enter", int'(bus.blink), 48);
        press(B_R);         check("nav.r1", int'(bus.blink), 12);
        press(B_R);         check("nav.r2", int'(bus.blink), 3);
        press(B_L);         check("nav.l1", int'(bus.blink), 12);
        press(B_L);         check("nav.l2", int'(bus.blink), 48);
        press(B_L);         check("nav.l3", int'(bus.blink), 3);
        press(B_L | B_R);   check("nav.lr", int'(bus.blink), 3);
        press(B_ESC);
        check("nav.esc.norm", int'(bus.norm), 1);
        check("nav.esc.blink", int'(bus.blink), 0);
        check_date("nav", 17, 6, 13);

        // Month change clamps the day
        set_date(17, 3, 31);
        press(B_L);
        check("clamp1.blink", int'(bus.blink), 12);
        press(B_DN);
        check_date("clamp1", 17, 2, 28);
        em = 2; ed = 28;
        press(B_ESC);

        // Year change out of a leap year clamps Feb 29
        set_date(20, 2, 29);
        press(B_L);
        press(B_L);
        check("clamp2.blink", int'(bus.blink), 48);
        press(B_UP);
        check_date("clamp2", 21, 2, 28);
        ey = 21; ed = 28;
        press(B_ESC);

        // Held carry advances exactly once
        set_date(17, 2, 28);
        press(B_ESC);
        @(negedge clk);
        bus.day_carry = 1'b1;
        repeat (100) @(negedge clk);
        check_date("hold", 17, 3, 1);
        bus.day_carry = 1'b0;
        repeat (2) @(negedge clk);
        bus.day_carry = 1'b1;
        repeat (2) @(negedge clk);
        bus.day_carry = 1'b0;
        @(negedge clk);
        check_date("second", 17, 3, 2);
        ey = 17; em = 3; ed = 2;

        // Leap year February
        set_date(20, 2, 28);
        press(B_ESC);
        carry_edge();
        check_date("leap29", 20, 2, 29);
        carry_edge();
        check_date("leapmar", 20, 3, 1);
        ey = 20; em = 3; ed = 1;

        // Century wrap
        set_date(99, 12, 31);
        press(B_ESC);
        carry_edge();
        check_date("wrap", 0, 1, 1);
`ifdef CALENDAR_WEEKDAY_EN
        check("wrap.weekday", int'(bus.weekday), 6);
`endif
        ey = 0; em = 1; ed = 1;

        // Priority: up+down cancels, esc beats adjust
        set_date(0, 1, 5);
        press(B_UP | B_DN);
        check("updn.day", int'(bus.day), 5);
        check("updn.blink", int'(bus.blink), 3);
        press(B_ESC | B_UP);
        check("escup.norm", int'(bus.norm), 1);
        check("escup.day", int'(bus.day), 5);

        // Carry during set mode is discarded, no spurious advance on exit
        press(B_EN);
        press(B_R);
        press(B_R);
        check("setd.blink", int'(bus.blink), 3);
        @(negedge clk);
        bus.day_carry = 1'b1;
        repeat (3) @(negedge clk);
        press(B_ESC);
        check("carryset.norm", int'(bus.norm), 1);
        repeat (3) @(negedge clk);
        check_date("carryset", 0, 1, 5);
        bus.day_carry = 1'b0;
        @(negedge clk);
        carry_edge();
        check_date("after", 0, 1, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
